// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - PS/2 device-side scan-code transmitter with input queue
// Queued bytes leave as 11-bit frames: start, data LSB first, odd parity, stop.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       frame_done,
  output logic       ps2_clk,
  output logic       ps2_data
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_PRE  = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
  state_e        state_q, state_d;
  logic [10:0]   frame_q, frame_d;
  logic [3:0]    bit_q, bit_d, bit_nxt;
  logic          low_q, low_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d, pclk_q, pclk_d, pdat_q, pdat_d;
  logic          push, pop;
  logic [7:0]    head;

  // A push while full is dropped even if the head pops in the same cycle.
  always_comb begin
    push       = wr_en && !full_q;
    pop        = (state_q == S_IDLE) && !empty_q;
    head       = mem_q[rd_ptr_q];
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d     = (count_d == (AW+1)'(FIFO_DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | (wr_en & full_q);
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    bit_nxt = bit_q + 4'd1;
    low_d   = low_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pclk_d  = pclk_q;
    pdat_d  = pdat_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          frame_d = {1'b1, ~^head, head, 1'b0};
          bit_d   = 4'd0;
          low_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          pclk_d  = 1'b1;
          pdat_d  = frame_d[0];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (!low_q) begin
          if (cnt_q == DIV_LAST) begin
            low_d  = 1'b1;
            cnt_d  = '0;
            pclk_d = 1'b0;
          end
        end else begin
          // Registered pulse: raise it one cycle early so it lands on the stop bit's last cycle.
          if (bit_q == 4'd10 && cnt_q == DIV_PRE) done_d = 1'b1;
          if (cnt_q == DIV_LAST) begin
            cnt_d  = '0;
            pclk_d = 1'b1;
            if (bit_q == 4'd10) begin
              pdat_d  = 1'b1;
              state_d = S_GAP;
            end else begin
              bit_d  = bit_nxt;
              low_d  = 1'b0;
              pdat_d = frame_q[bit_nxt];
            end
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      frame_q    <= '1;
      bit_q      <= 4'd0;
      low_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pclk_q     <= 1'b1;
      pdat_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_q      <= bit_d;
      low_q      <= low_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pclk_q     <= pclk_d;
      pdat_q     <= pdat_d;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign ps2_clk    = pclk_q;
  assign ps2_data   = pdat_q;
endmodule
